// File: rtl/pp_mul_sched_pkg.sv
// Shared widths, tag type and stats width for the pp_mul_share_sched scheduler.
package pp_mul_sched_pkg;

    localparam int A_W     = 12;
    localparam int B_W     = 9;
    localparam int P_W     = A_W + B_W;
    localparam int MUL_LAT = 3;
    localparam int ID_W    = 3;
    localparam int STAT_W  = 32;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/pp_mul_sched_rr_arb.sv
// Round-robin arbiter: scans upward from rr_ptr with wrap, advances the pointer past each winner.
module pp_mul_sched_rr_arb
    import pp_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               granted,
    output logic [ID_W-1:0]    rr_ptr
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    int          scan;
    logic [IW-1:0] idx;

    // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        granted  = 1'b0;
        scan     = 0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            idx = IW'(scan);
            if (enable && !granted && req[idx]) begin
                granted    = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(scan);
            end
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/pp_mul_share_sched.sv
// Time-shares one pipelined multiplier among NUM_REQ requesters; tag pipeline routes products home.
// Optional stats counters are built when PP_MUL_SCHED_STATS_EN is defined.
module pp_mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = pp_mul_sched_pkg::A_W,
    parameter int B_W     = pp_mul_sched_pkg::B_W,
    parameter int P_W     = pp_mul_sched_pkg::P_W,
    parameter int MUL_LAT = pp_mul_sched_pkg::MUL_LAT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sched_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [P_W-1:0]         rsp_p,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic                   idle
`ifdef PP_MUL_SCHED_STATS_EN
    ,
    output logic [pp_mul_sched_pkg::STAT_W-1:0] stat_issue_cnt,
    output logic [pp_mul_sched_pkg::STAT_W-1:0] stat_stall_cnt
`endif
);

    import pp_mul_sched_pkg::tag_t;
    import pp_mul_sched_pkg::ID_W;

    tag_t            tags [MUL_LAT];
    tag_t            head;
    logic            head_ready;
    logic            issue;
    logic            any_vld;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] sel;

    assign head = tags[MUL_LAT-1];

    always_comb begin
        rsp_valid  = '0;
        head_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head.id == ID_W'(i)) begin
                rsp_valid[i] = head.vld;
                head_ready   = rsp_ready[i];
            end
        end
    end

    // An unaccepted head freezes the whole multiplier so its product is held on dout.
    assign mul_ce = !(head.vld && !head_ready);
    assign rsp_p  = mul_dout;

    pp_mul_sched_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req_valid),
        .enable   (sched_en && mul_ce),
        .grant    (req_ready),
        .grant_id (grant_id),
        .granted  (issue),
        .rr_ptr   (rr_ptr)
    );

    assign sel = issue ? grant_id : rr_ptr;

    always_comb begin
        mul_din0 = req_a[A_W-1:0];
        mul_din1 = req_b[B_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    // NOTE: the tag pipeline is a few flops of control state and is reset; the multiplier's data stages are not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
        end else if (mul_ce) begin
            tags[0] <= '{vld: issue, id: grant_id};
            for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) any_vld = any_vld | tags[i].vld;
    end

    assign idle = !any_vld && !issue;

`ifdef PP_MUL_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (issue && (stat_issue_cnt != '1)) stat_issue_cnt <= stat_issue_cnt + 1'b1;
            if (!mul_ce && (stat_stall_cnt != '1)) stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pp_mul_share_sched.sv
// Self-checking bench for pp_mul_share_sched: queue-based reference model with ages, plus a ce-gated multiplier.
module tb_pp_mul_share_sched;

    localparam int NR  = 4;
    localparam int AW  = 12;
    localparam int BW  = 9;
    localparam int PW  = 21;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sched_en;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [PW-1:0]    rsp_p;
    logic             mul_ce;
    logic [AW-1:0]    mul_din0;
    logic [BW-1:0]    mul_din1;
    logic [PW-1:0]    mul_dout;
    logic             idle;
`ifdef PP_MUL_SCHED_STATS_EN
    logic [31:0]      stat_issue_cnt;
    logic [31:0]      stat_stall_cnt;
`endif

    pp_mul_share_sched #(
        .NUM_REQ (NR), .A_W (AW), .B_W (BW), .P_W (PW), .MUL_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sched_en  (sched_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .idle      (idle)
`ifdef PP_MUL_SCHED_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: LAT ce-gated stages, no reset on data.
    logic signed [PW-1:0] mst [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mst[0] <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
            for (int i = 1; i < LAT; i++) mst[i] <= mst[i-1];
        end
    end
    assign mul_dout = mst[LAT-1];

    // Reference model: in-flight ops in issue order, each aging by one per ce-enabled edge.
    typedef struct {
        int            id;
        logic [PW-1:0] p;
        int            age;
    } op_t;

    op_t fl[$];
    int  rr      = 0;
    int  n_issue = 0;
    int  n_stall = 0;
    int  obs_rsp = 0;
    int  total   = 0;
    int  bad     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i);
        req_a[i*AW +: AW] = AW'($urandom);
        req_b[i*BW +: BW] = BW'($urandom);
        req_valid[i]      = 1'b1;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic tick(input int new_pct);
        logic                 head_v;
        int                   hid;
        logic                 exp_ce;
        logic                 exp_issue;
        logic                 found;
        int                   win;
        logic [NR-1:0]        cand;
        logic [NR-1:0]        exp_rv;
        logic [NR-1:0]        exp_rr;
        logic [AW-1:0]        a;
        logic signed [BW-1:0] b;
        logic signed [PW-1:0] prod;
        #1;
        head_v = (fl.size() > 0) && (fl[0].age == LAT);
        hid    = head_v ? fl[0].id : 0;
        exp_rv = '0;
        if (head_v) exp_rv[hid] = 1'b1;
        exp_ce    = !(head_v && !rsp_ready[hid]);
        cand      = sched_en ? req_valid : '0;
        exp_issue = exp_ce && (cand != '0);
        found     = 1'b0;
        win       = 0;
        for (int k = 0; k < NR; k++) begin
            if (!found && cand[(rr + k) % NR]) begin
                found = 1'b1;
                win   = (rr + k) % NR;
            end
        end
        exp_rr = '0;
        if (exp_issue) exp_rr[win] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("mul_ce", 32'(mul_ce), 32'(exp_ce));
        check("idle", 32'(idle), 32'((fl.size() == 0) && !exp_issue));
        if (head_v) check("rsp_p", 32'(rsp_p), 32'(fl[0].p));
        if (|(rsp_valid & rsp_ready)) obs_rsp++;
        a    = req_a[win*AW +: AW];
        b    = req_b[win*BW +: BW];
        prod = $signed({1'b0, a}) * b;
        @(posedge clk);
        if (exp_ce) begin
            if (head_v && rsp_ready[hid]) void'(fl.pop_front());
            foreach (fl[i]) fl[i].age++;
            if (exp_issue) begin
                fl.push_back('{id: win, p: prod, age: 1});
                rr = (win + 1) % NR;
                n_issue++;
            end
        end else begin
            n_stall++;
        end
        #1;
        if (exp_issue) req_valid[win] = 1'b0;
        for (int i = 0; i < NR; i++)
            if (!req_valid[i] && ($urandom_range(99) < new_pct)) set_op(i);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] single_exp;
        int            base;
        logic          hit;
        single_exp = -21'sd1048320;

        // Reset state
        reset_n   = 1'b0;
        sched_en  = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mul_ce", 32'(mul_ce), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single op from requester 2
        req_a[2*AW +: AW] = 12'd4095;
        req_b[2*BW +: BW] = 9'h100;
        req_valid[2]      = 1'b1;
        #1;
        check("single_grant", 32'(req_ready), 32'b0100);
        tick(0);
        tick(0);
        tick(0);
        #1;
        check("single_valid", 32'(rsp_valid), 32'b0100);
        check("single_p", 32'(rsp_p), 32'(single_exp));
        tick(0);
        repeat (2) tick(0);

        // Round-robin with all requesters continuously valid
        for (int i = 0; i < NR; i++) set_op(i);
        repeat (12) tick(100);

        // Backpressure on requester 1 while its result sits at the head
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            if (fl.size() > 0 && fl[0].age == LAT && fl[0].id == 1) hit = 1'b1;
            else tick(100);
        end
        check("bp_found_head", 32'(hit), 32'd1);
        rsp_ready[1] = 1'b0;
        repeat (5) begin
            #1;
            check("bp_ce_low", 32'(mul_ce), 32'd0);
            tick(100);
        end
        rsp_ready = '1;
        repeat (10) tick(100);

        // Drain with sched_en low and three ops in flight
        sched_en = 1'b0;
        base     = obs_rsp;
        repeat (6) tick(0);
        check("drain_count", 32'(obs_rsp - base), 32'd3);
        check("drain_idle", 32'(idle), 32'd1);
        sched_en = 1'b1;
        repeat (6) tick(100);

        // Reset with operations in flight
        req_valid = '0;
        reset_n   = 1'b0;
        fl.delete();
        rr      = 0;
        n_issue = 0;
        n_stall = 0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) tick(0);
        for (int i = 0; i < NR; i++) set_op(i);
        #1;
        check("rst_rr_restart", 32'(req_ready), 32'b0001);
        repeat (4) tick(0);

        // Randomized traffic with random backpressure and occasional sched_en drops
        for (int n = 0; n < 300; n++) begin
            rsp_ready = NR'($urandom);
            sched_en  = ($urandom_range(9) != 0);
            tick(50);
        end
        rsp_ready = '1;
        sched_en  = 1'b0;
        repeat (LAT + 2) tick(0);
        check("final_idle", 32'(idle), 32'd1);

`ifdef PP_MUL_SCHED_STATS_EN
        check("stat_issue_cnt", stat_issue_cnt, 32'(n_issue));
        check("stat_stall_cnt", stat_stall_cnt, 32'(n_stall));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
